// File: rtl/sisc_ifetch.sv
// Instruction-fetch front end for the sisc core: owns the fetch PC, issues word reads over
// a req/ack handshake and presents prefetched words in order through a small buffer.
module sisc_ifetch #(
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_f,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ack,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    input  logic              halt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] fpc, fpc_d, addr_d;
    logic              req_d;
    logic              push, pop;

    logic [31:0]       buf_data [DEPTH];
    logic [ADDR_W-1:0] buf_pc   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_next;
    logic [CNT_W-1:0]  count, count_d, count_popped;

    assign ir_valid     = (count != '0);
    assign pop          = ir_valid && ir_ack && !br_taken;
    assign count_popped = count - CNT_W'(pop);
    assign rd_next      = rd_ptr + PTR_W'(pop);
    assign count_d      = br_taken ? '0 : count_popped + CNT_W'(push);

    always_comb begin
        state_d = state;
        req_d   = imem_req;
        addr_d  = imem_addr;
        fpc_d   = fpc;
        push    = 1'b0;
        case (state)
            IDLE: begin
                if (br_taken) begin
                    fpc_d = br_addr;
                end else if (!halt && (count < CNT_W'(DEPTH))) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = fpc;
                end
            end
            REQ: begin
                if (imem_ack && br_taken) begin
                    fpc_d   = br_addr;
                    req_d   = 1'b0;
                    state_d = IDLE;
                end else if (imem_ack) begin
                    push  = 1'b1;
                    fpc_d = fpc + ADDR_W'(1);
                    // Stream back-to-back only while the buffer still has room after this push.
                    if (!halt && ((count_popped + CNT_W'(1)) < CNT_W'(DEPTH))) begin
                        addr_d = fpc + ADDR_W'(1);
                    end else begin
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end
                end else if (br_taken) begin
                    fpc_d   = br_addr;
                    state_d = DROP;
                end
            end
            DROP: begin
                if (br_taken) begin
                    fpc_d = br_addr;
                end
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            fpc       <= RESET_PC;
        end else begin
            state     <= state_d;
            imem_req  <= req_d;
            imem_addr <= addr_d;
            fpc       <= fpc_d;
        end
    end

    // ir/ir_pc are registered copies of the next head so they keep the last word once empty.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            ir     <= '0;
            ir_pc  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else begin
            count <= count_d;
            if (br_taken) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    buf_data[wr_ptr] <= imem_rdata;
                    buf_pc[wr_ptr]   <= imem_addr;
                    wr_ptr           <= wr_ptr + PTR_W'(1);
                end
                rd_ptr <= rd_next;
            end
            if (count_d != '0) begin
                if (count_popped == '0) begin
                    ir    <= imem_rdata;
                    ir_pc <= imem_addr;
                end else begin
                    ir    <= buf_data[rd_next];
                    ir_pc <= buf_pc[rd_next];
                end
            end
        end
    end

endmodule

// File: tb/tb_sisc_ifetch.sv
// Self-checking bench for sisc_ifetch: directed scenarios plus random traffic, all compared
// against a queue-based reference model of the fetch front end.
module tb_sisc_ifetch;

    localparam int ADDR_W = 16;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst_f = 1'b0;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack = 1'b0;
    logic [31:0]       imem_rdata = '0;
    logic [31:0]       ir;
    logic [ADDR_W-1:0] ir_pc;
    logic              ir_valid;
    logic              ir_ack = 1'b0;
    logic              br_taken = 1'b0;
    logic [ADDR_W-1:0] br_addr = '0;
    logic              halt = 1'b0;

    int errors = 0;
    int checks = 0;

    sisc_ifetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk(clk), .rst_f(rst_f),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ack(ir_ack),
        .br_taken(br_taken), .br_addr(br_addr), .halt(halt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       d;
    } ent_t;

    ent_t              m_q[$];
    logic [ADDR_W-1:0] m_fpc;
    logic [ADDR_W-1:0] m_addr;
    bit                m_req;
    bit                m_drop;

    function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] a);
        return {~a, a} ^ 32'h1234_8001;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fpc  = '0;
        m_addr = '0;
        m_req  = 0;
        m_drop = 0;
    endtask

    // One clock of the fetch front end, stated as queue operations on the prefetch buffer.
    task automatic model_step(input bit a, input bit k, input bit b,
                              input logic [ADDR_W-1:0] ba, input bit h);
        int  n;
        bit  popm;
        n    = m_q.size();
        popm = (n > 0) && k && !b;
        if (popm) void'(m_q.pop_front());
        if (m_req) begin
            if (a) begin
                if (!m_drop && !b) begin
                    m_q.push_back('{pc: m_addr, d: word_of(m_addr)});
                    m_fpc = m_addr + 1'b1;
                    if (!h && m_q.size() < DEPTH) m_addr = m_fpc;
                    else m_req = 0;
                end else begin
                    m_req = 0;
                end
                m_drop = 0;
            end else if (b) begin
                m_drop = 1;
            end
        end else if (!b && !h && n < DEPTH) begin
            m_req  = 1;
            m_addr = m_fpc;
        end
        if (b) begin
            m_q.delete();
            m_fpc = ba;
        end
    endtask

    task automatic check_output(input string tag);
        check({tag, "_req"}, {31'd0, imem_req}, {31'd0, m_req});
        if (m_req) check({tag, "_addr"}, {16'd0, imem_addr}, {16'd0, m_addr});
        check({tag, "_valid"}, {31'd0, ir_valid}, {31'd0, m_q.size() != 0});
        if (m_q.size() != 0) begin
            check({tag, "_ir"}, ir, m_q[0].d);
            check({tag, "_irpc"}, {16'd0, ir_pc}, {16'd0, m_q[0].pc});
        end
    endtask

    // Called just after a falling edge: drive one cycle of inputs, advance the model, check.
    task automatic apply_stimulus(input string tag, input bit a, input bit k, input bit b,
                                  input logic [ADDR_W-1:0] ba, input bit h);
        imem_ack   = a;
        imem_rdata = a ? word_of(imem_addr) : $urandom();
        ir_ack     = k;
        br_taken   = b;
        br_addr    = ba;
        halt       = h;
        model_step(a, k, b, ba, h);
        @(posedge clk);
        #1;
        check_output(tag);
        @(negedge clk);
    endtask

    task automatic apply_reset(input string tag);
        rst_f    = 1'b0;
        imem_ack = 1'b0;
        ir_ack   = 1'b0;
        br_taken = 1'b0;
        halt     = 1'b0;
        #1;
        check({tag, "_rst_req"}, {31'd0, imem_req}, 32'd0);
        check({tag, "_rst_valid"}, {31'd0, ir_valid}, 32'd0);
        check({tag, "_rst_addr"}, {16'd0, imem_addr}, 32'd0);
        check({tag, "_rst_ir"}, ir, 32'd0);
        check({tag, "_rst_irpc"}, {16'd0, ir_pc}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_f = 1'b1;
    endtask

    initial begin
        bit a;
        // Scenario 1: ack every cycle, core always consuming -> addresses stream 0,1,2,...
        apply_reset("t1");
        apply_stimulus("t1", 0, 1, 0, '0, 0);
        check("t1_first_addr", {16'd0, imem_addr}, 32'd0);
        for (int i = 0; i < 8; i++) apply_stimulus("t1", 1, 1, 0, '0, 0);
        check("t1_stream_addr", {16'd0, imem_addr}, 32'd8);
        check("t1_stream_irpc", {16'd0, ir_pc}, 32'd7);

        // Scenario 2: no consumption -> two reads fill the buffer, then one pop frees one slot.
        apply_reset("t2");
        for (int i = 0; i < 5; i++) apply_stimulus("t2", 1, 0, 0, '0, 0);
        check("t2_full_req", {31'd0, imem_req}, 32'd0);
        check("t2_full_ir", ir, word_of(16'd0));
        apply_stimulus("t2", 0, 1, 0, '0, 0);
        check("t2_pop_ir", ir, word_of(16'd1));
        apply_stimulus("t2", 0, 0, 0, '0, 0);
        check("t2_new_addr", {16'd0, imem_addr}, 32'd2);
        apply_stimulus("t2", 1, 0, 0, '0, 0);

        // Scenario 3: redirect while the read of address 5 is still outstanding.
        apply_reset("t3");
        apply_stimulus("t3", 0, 0, 1, 16'd5, 0);
        apply_stimulus("t3", 0, 0, 0, '0, 0);
        apply_stimulus("t3", 0, 0, 0, '0, 0);
        apply_stimulus("t3", 0, 0, 1, 16'h0040, 0);
        check("t3_drop_valid", {31'd0, ir_valid}, 32'd0);
        check("t3_drop_addr", {16'd0, imem_addr}, 32'd5);
        apply_stimulus("t3", 0, 0, 0, '0, 0);
        apply_stimulus("t3", 1, 0, 0, '0, 0);
        apply_stimulus("t3", 0, 0, 0, '0, 0);
        check("t3_redirect_addr", {16'd0, imem_addr}, 32'h40);
        apply_stimulus("t3", 1, 0, 0, '0, 0);
        check("t3_irpc", {16'd0, ir_pc}, 32'h40);

        // Scenario 4: branch, memory ack and core ack collide with one buffered word.
        apply_reset("t4");
        apply_stimulus("t4", 0, 0, 0, '0, 0);
        apply_stimulus("t4", 1, 0, 0, '0, 0);
        apply_stimulus("t4", 1, 1, 1, 16'h0123, 0);
        check("t4_flush_valid", {31'd0, ir_valid}, 32'd0);
        apply_stimulus("t4", 0, 0, 0, '0, 0);
        check("t4_br_addr", {16'd0, imem_addr}, 32'h123);

        // Scenario 5: halt during an outstanding read still lets that read land.
        apply_reset("t5");
        apply_stimulus("t5", 0, 0, 0, '0, 0);
        apply_stimulus("t5", 1, 1, 0, '0, 1);
        for (int i = 0; i < 3; i++) apply_stimulus("t5", 0, 1, 0, '0, 1);
        check("t5_halt_req", {31'd0, imem_req}, 32'd0);
        apply_stimulus("t5", 0, 0, 0, '0, 0);
        check("t5_resume_addr", {16'd0, imem_addr}, 32'd1);

        // Random traffic, including acks while idle and branches in every state.
        for (int i = 0; i < 600; i++) begin
            a = m_req ? ($urandom_range(99) < 60) : ($urandom_range(99) < 10);
            apply_stimulus("rnd", a, $urandom_range(99) < 50, $urandom_range(99) < 8,
                           ADDR_W'($urandom()), $urandom_range(99) < 15);
        end

        // Scenario 6: asynchronous reset in the middle of an outstanding read.
        apply_stimulus("t6", 0, 0, 0, '0, 0);
        if (!m_req) apply_stimulus("t6", 0, 0, 0, '0, 0);
        apply_reset("t6");
        apply_stimulus("t6", 0, 0, 0, '0, 0);
        check("t6_first_addr", {16'd0, imem_addr}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
